mem_axi_bridge: RTL and testbench
=================================

# mem_axi_bridge

Single-outstanding AXI-lite master that converts the CPU's simple memory request (the `ce`/`we`/`addr`/`wdata`/`wmask` style used by the fetch and LSU paths) into transactions on the five AXI-lite channels of `AXIMem`. It sits directly upstream of `AXIMem` and replaces the combinational DPI memory path with a registered, handshaked bus access. One instance serves instruction fetch and a second serves data.

## Interface
- `BUS_WIDTH`, 32, address width on AR/AW.
- `DATA_WIDTH`, 32, data width on RD/WD; `wstrb` is `DATA_WIDTH/8`.
- `PROT`, 3'b000, constant driven on `ar_prot`/`aw_prot`; the fetch instance uses 3'b100.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  bridge idle and able to accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  BUS_WIDTH  byte address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wmask`  in  DATA_WIDTH/8  byte enables.
- `resp_valid`  out  1  transaction complete.
- `resp_ready`  in  1  CPU consumes the response.
- `resp_rdata`  out  DATA_WIDTH  read data; 0 for writes.
- `resp_err`  out  1  write response was not OKAY.
- `ar_valid`/`ar_ready`/`ar_addr`/`ar_prot`: read address channel, master side.
- `aw_valid`/`aw_ready`/`aw_addr`/`aw_prot`: write address channel, master side.
- `rd_valid`/`rd_ready`/`rd_data`: read data channel (`rd_ready` is an output).
- `wd_valid`/`wd_ready`/`wd_data`/`wstrb`: write data channel.
- `wr_valid`/`wr_ready`/`wr_breap`: write response channel (`wr_ready` is an output; `wr_breap` is 2 bits).

## Operation
- FSM states: IDLE, AR, RD, WA, WB, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` with `req_we`=0: latch the address and go to AR.
  - On `req_valid` with `req_we`=1: latch address, data and mask, clear the `aw_done`/`w_done` flags, and go to WA.
- AR: `ar_valid`=1 until `ar_ready`, then go to RD.
- RD: `rd_ready`=1. On `rd_valid`, capture `rd_data`, set `resp_err`=0, and go to RESP.
- WA:
  - `aw_valid`=~`aw_done` and `wd_valid`=~`w_done`, driven independently.
  - Each handshake sets its own done flag.
  - When both flags are set, or both handshakes complete in the same cycle, go to WB.
- WB: `wr_ready`=1. On `wr_valid`, set `resp_err`=(`wr_breap`!=2'b00), set `resp_rdata`=0, and go to RESP.
- RESP: `resp_valid`=1, held with data stable until `resp_ready`, then go to IDLE.
- Address, data and strobe outputs come from the latched request and stay stable while the corresponding valid is high. `req_*` is ignored outside IDLE.
- A valid, once asserted, never drops before its handshake completes.
- Only one transaction is outstanding. No read/write reordering.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from any AXI input to any AXI output.
- Reset values:
  - state=IDLE, `req_ready`=1.
  - All AXI valids and readies = 0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - Latched addr/data/mask = 0.
- Cycle numbering with an always-ready slave: accept at edge 0.
  - Read: `ar_valid` high in cycle 1 and handshakes. Data handshake in cycle 2. `resp_valid` high in cycle 3.
  - Write: AW and W handshake in cycle 1. B handshake in cycle 2. `resp_valid` high in cycle 3.
- Back-to-back: `req_ready` rises in the cycle after the `resp_valid`&`resp_ready` edge, so throughput is at most 1 access per 4 cycles.
- Slave stalls extend the corresponding state indefinitely. There is no timeout.
- AW and W skew: either may complete first, in any cycle order. The bridge must not re-issue the channel that has already completed.
- Reset asserted mid-transaction: all valids and readies drop immediately (asynchronously), the FSM returns to IDLE, and the transaction is abandoned with no response.

## Structure
- Shared package `axi_pkg`:
  - FSM state enum.
  - Response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Default prot constants.
- No sub-module. Single flat module of roughly 150–250 lines of RTL.

## Test plan
- Read, slave always ready, memory[0x8000_0000]=0x1234_5678: request read 0x8000_0000 -> `ar_addr`=0x8000_0000 in cycle 1; `resp_valid` in cycle 3 with `resp_rdata`=0x1234_5678 and `resp_err`=0.
- Write with `wmask`=4'b0011, `wdata`=0xAABB_CCDD to 0x8000_0010 -> `wstrb`=4'b0011 and `wd_data`=0xAABB_CCDD; `resp_valid` in cycle 3; a subsequent read returns only the low half updated.
- Skew: `aw_ready` delayed 3 cycles, `wd_ready` immediate -> `wd_valid` high exactly 1 cycle, `aw_valid` high 4 cycles, then WB entered.
- Error: slave returns `wr_breap`=2'b10 -> `resp_err`=1. Then `resp_ready` held low 5 cycles -> `resp_valid` and data held stable throughout; `req_ready`=0 until release.
- Stall: `ar_ready` low 10 cycles, then `rd_valid` delayed 2 cycles -> `ar_addr` stable throughout and `rd_ready` high from the cycle after the AR handshake. Meanwhile toggle `req_valid` with new addresses -> they are ignored.
- Reset pulse while in RD -> `rd_ready`, `resp_valid` and `req_ready` reach their reset values without a clock edge; after release, a new read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions for the CPU memory bridges.
// Contents: bridge FSM state encoding, AXI response codes, default
// protection attributes for the data and instruction-fetch instances.
package axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_RD,
    S_WA,
    S_WB,
    S_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DATA = 3'b000;
  localparam logic [2:0] PROT_INSN = 3'b100;

endpackage

// File: rtl/mem_axi_bridge_if.sv
// Bundle of the CPU request/response handshake and the five AXI-lite
// channels between the bridge and the memory slave.
// master : bridge view (accepts CPU requests, drives AR/AW/W, sinks R/B)
// slave  : environment view (CPU requester plus AXI-lite memory)
interface mem_axi_bridge_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  // CPU side
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [BUS_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wmask;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;
  // AXI-lite read
  logic                    ar_valid;
  logic                    ar_ready;
  logic [BUS_WIDTH-1:0]    ar_addr;
  logic [2:0]              ar_prot;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  // AXI-lite write
  logic                    aw_valid;
  logic                    aw_ready;
  logic [BUS_WIDTH-1:0]    aw_addr;
  logic [2:0]              aw_prot;
  logic                    wd_valid;
  logic                    wd_ready;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [1:0]              wr_breap;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
           ar_ready, rd_valid, rd_data, aw_ready, wd_ready, wr_valid, wr_breap,
    output req_ready, resp_valid, resp_rdata, resp_err,
           ar_valid, ar_addr, ar_prot, rd_ready,
           aw_valid, aw_addr, aw_prot, wd_valid, wd_data, wstrb, wr_ready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
           ar_ready, rd_valid, rd_data, aw_ready, wd_ready, wr_valid, wr_breap,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           ar_valid, ar_addr, ar_prot, rd_ready,
           aw_valid, aw_addr, aw_prot, wd_valid, wd_data, wstrb, wr_ready
  );
endinterface

// File: rtl/mem_axi_bridge.sv
// Single-outstanding AXI-lite master: turns one CPU memory request into
// an AR/R or AW+W/B transaction and returns a response to the CPU.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset; abandons any transaction
//   bus   - mem_axi_bridge_if.master (CPU req/resp + AXI-lite channels)
// Every output is a flop, so no AXI input reaches an AXI output
// combinationally.
module mem_axi_bridge
  import axi_pkg::*;
#(
  parameter int         BUS_WIDTH  = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = PROT_DATA
) (
  input logic             clk,
  input logic             reset,
  mem_axi_bridge_if.master bus
);

  state_e                  state_q;
  logic                    req_ready_q;
  logic                    ar_valid_q, rd_ready_q;
  logic                    aw_valid_q, wd_valid_q, wr_ready_q;
  logic                    aw_done_q, w_done_q;
  logic                    resp_valid_q, resp_err_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic [BUS_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;

  logic aw_hs, w_hs, aw_fin_d, w_fin_d;

  assign aw_hs    = aw_valid_q & bus.aw_ready;
  assign w_hs     = wd_valid_q & bus.wd_ready;
  // A channel counts as finished if it completed earlier or completes now.
  assign aw_fin_d = aw_done_q | aw_hs;
  assign w_fin_d  = w_done_q  | w_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      ar_valid_q   <= 1'b0;
      rd_ready_q   <= 1'b0;
      aw_valid_q   <= 1'b0;
      wd_valid_q   <= 1'b0;
      wr_ready_q   <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            addr_q      <= bus.req_addr;
            if (bus.req_we) begin
              wdata_q    <= bus.req_wdata;
              wmask_q    <= bus.req_wmask;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
              aw_valid_q <= 1'b1;
              wd_valid_q <= 1'b1;
              state_q    <= S_WA;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= S_AR;
            end
          end
        end
        S_AR: begin
          if (bus.ar_ready) begin
            ar_valid_q <= 1'b0;
            rd_ready_q <= 1'b1;
            state_q    <= S_RD;
          end
        end
        S_RD: begin
          if (bus.rd_valid) begin
            rd_ready_q   <= 1'b0;
            resp_rdata_q <= bus.rd_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WA: begin
          // AW and W retire independently; a retired channel is never re-issued.
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            wd_valid_q <= 1'b0;
            w_done_q   <= 1'b1;
          end
          if (aw_fin_d && w_fin_d) begin
            wr_ready_q <= 1'b1;
            state_q    <= S_WB;
          end
        end
        S_WB: begin
          if (bus.wr_valid) begin
            wr_ready_q   <= 1'b0;
            resp_err_q   <= (bus.wr_breap != RESP_OKAY);
            resp_rdata_q <= '0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ar_valid   = ar_valid_q;
  assign bus.ar_addr    = addr_q;
  assign bus.ar_prot    = PROT;
  assign bus.rd_ready   = rd_ready_q;
  assign bus.aw_valid   = aw_valid_q;
  assign bus.aw_addr    = addr_q;
  assign bus.aw_prot    = PROT;
  assign bus.wd_valid   = wd_valid_q;
  assign bus.wd_data    = wdata_q;
  assign bus.wstrb      = wmask_q;
  assign bus.wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a small AXI-lite memory slave with
// programmable readies/latency, a vector table of single transactions,
// and hand sequences for skew, error/backpressure, stall and reset.
module tb_mem_axi_bridge;

  logic clk;
  logic reset;

  mem_axi_bridge_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_axi_bridge #(.BUS_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- memory slave ----------------
  logic [31:0] mem [0:15];
  logic        rd_pend, aw_got, w_got, b_pend;
  int          rd_cnt, rd_dly;
  logic [31:0] rd_addr, waddr, wdat;
  logic [3:0]  wst;
  logic [1:0]  bresp_cfg;
  logic        s_aw_hs, s_w_hs;

  assign s_aw_hs      = bus.aw_valid && bus.aw_ready;
  assign s_w_hs       = bus.wd_valid && bus.wd_ready;
  assign bus.rd_valid = rd_pend && (rd_cnt == 0);
  assign bus.rd_data  = mem[rd_addr[5:2]];
  assign bus.wr_valid = b_pend;
  assign bus.wr_breap = bresp_cfg;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h1234_5678;
      mem[1]  <= 32'hDEAD_BEEF;
      mem[4]  <= 32'h1122_3344;
      rd_pend <= 1'b0;
      rd_cnt  <= 0;
      rd_addr <= 32'h0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      b_pend  <= 1'b0;
      waddr   <= 32'h0;
      wdat    <= 32'h0;
      wst     <= 4'h0;
    end else begin
      if (bus.ar_valid && bus.ar_ready) begin
        rd_pend <= 1'b1;
        rd_addr <= bus.ar_addr;
        rd_cnt  <= rd_dly;
      end else if (rd_pend && rd_cnt != 0) begin
        rd_cnt <= rd_cnt - 1;
      end
      if (bus.rd_valid && bus.rd_ready) rd_pend <= 1'b0;
      if (s_aw_hs) begin
        aw_got <= 1'b1;
        waddr  <= bus.aw_addr;
      end
      if (s_w_hs) begin
        w_got <= 1'b1;
        wdat  <= bus.wd_data;
        wst   <= bus.wstrb;
      end
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs)) begin
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        b_pend <= 1'b0;
        for (int b = 0; b < 4; b++)
          if (wst[b]) mem[waddr[5:2]][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  bresp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Presents a request; returns at cycle 1 (#1 after the accept edge).
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts cycles until resp_valid, starting at cycle 'start'; bounded.
  task automatic wait_resp(input int start, output int c);
    c = start;
    while (!bus.resp_valid && c < start + 60) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic release_resp(input string nm);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk({nm, ".req_ready_after"}, bus.req_ready, 1'b1);
    chk({nm, ".resp_valid_after"}, bus.resp_valid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int c;
    bresp_cfg = v.bresp;
    issue(v.we, v.addr, v.wdata, v.wmask);
    if (!v.we) begin
      chk({nm, ".ar_valid_c1"}, bus.ar_valid, 1'b1);
      chk({nm, ".ar_addr_c1"}, bus.ar_addr, v.addr);
    end else begin
      chk({nm, ".aw_addr_c1"}, bus.aw_addr, v.addr);
      chk({nm, ".wd_data_c1"}, bus.wd_data, v.wdata);
      chk({nm, ".wstrb_c1"}, {28'h0, bus.wstrb}, {28'h0, v.wmask});
    end
    wait_resp(1, c);
    chk({nm, ".latency"}, c, 3);
    chk({nm, ".rdata"}, bus.resp_rdata, v.exp_rdata);
    chk({nm, ".err"}, bus.resp_err, v.exp_err);
    release_resp(nm);
  endtask

  vec_t vecs [7];

  initial begin
    int c, aw_n, w_n, bad;

    vecs[0] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0,    2'b00, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0011, 2'b00, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0,    2'b00, 32'h1122_CCDD, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0004, 32'h5566_7788, 4'b1100, 2'b01, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h8000_0004, 32'h0,         4'h0,    2'b00, 32'h5566_BEEF, 1'b0};
    vecs[5] = '{1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'b1111, 2'b11, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 32'h8000_0008, 32'h0,         4'h0,    2'b00, 32'hCAFE_F00D, 1'b0};

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wmask  = 4'h0;
    bus.resp_ready = 1'b0;
    bus.ar_ready   = 1'b1;
    bus.aw_ready   = 1'b1;
    bus.wd_ready   = 1'b1;
    rd_dly         = 0;
    bresp_cfg      = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", bus.req_ready, 1'b1);
    chk("rst.valids", {bus.ar_valid, bus.aw_valid, bus.wd_valid, bus.resp_valid}, 4'h0);
    chk("rst.readies", {bus.rd_ready, bus.wr_ready}, 2'b00);
    chk("rst.resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst.resp_err", bus.resp_err, 1'b0);
    chk("rst.addr", bus.ar_addr, 32'h0);
    chk("rst.wdata", bus.wd_data, 32'h0);
    chk("rst.wstrb", {28'h0, bus.wstrb}, 32'h0);
    chk("rst.prot", {bus.ar_prot, bus.aw_prot}, 6'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table: single transactions against an always-ready slave.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Skew: AW ready held off for cycles 1-3, W ready immediately.
    bus.aw_ready = 1'b0;
    bresp_cfg    = 2'b00;
    issue(1'b1, 32'h8000_0020, 32'h0BAD_CAFE, 4'hF);
    aw_n = 0;
    w_n  = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      aw_n += int'(bus.aw_valid);
      w_n  += int'(bus.wd_valid);
      if (cyc == 4) bus.aw_ready = 1'b1;
      if (cyc == 5) chk("skew.wr_ready_c5", bus.wr_ready, 1'b1);
      if (cyc < 5) begin
        @(posedge clk);
        #1;
      end
    end
    chk("skew.aw_valid_cycles", aw_n, 4);
    chk("skew.wd_valid_cycles", w_n, 1);
    wait_resp(5, c);
    chk("skew.latency", c, 6);
    chk("skew.err", bus.resp_err, 1'b0);
    release_resp("skew");
    run_vec('{1'b0, 32'h8000_0020, 32'h0, 4'h0, 2'b00, 32'h0BAD_CAFE, 1'b0}, "skew_rb");

    // Error response, then CPU backpressure for 5 cycles.
    bresp_cfg = 2'b10;
    issue(1'b1, 32'h8000_0024, 32'h1357_9BDF, 4'hF);
    wait_resp(1, c);
    chk("err.latency", c, 3);
    chk("err.resp_err", bus.resp_err, 1'b1);
    chk("err.rdata", bus.resp_rdata, 32'h0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!bus.resp_valid || !bus.resp_err || bus.resp_rdata != 32'h0 || bus.req_ready) bad++;
      @(posedge clk);
      #1;
    end
    chk("err.hold_stable", bad, 0);
    release_resp("err");
    bresp_cfg = 2'b00;

    // AR stall 10 cycles, R delayed 2; new requests meanwhile are ignored.
    bus.ar_ready = 1'b0;
    rd_dly       = 2;
    issue(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    bad = 0;
    aw_n = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc <= 11 && (!bus.ar_valid || bus.ar_addr != 32'h8000_0000)) bad++;
      if (cyc >= 12 && !bus.rd_ready) aw_n++;
      if (bus.aw_valid || bus.wd_valid) bad++;
      if (cyc <= 10) begin
        bus.req_valid = cyc[0];
        bus.req_we    = cyc[1];
        bus.req_addr  = 32'h8000_0040 + 32'(cyc * 4);
      end
      if (cyc == 11) begin
        bus.req_valid = 1'b0;
        bus.ar_ready  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk("stall.ar_stable", bad, 0);
    chk("stall.rd_ready_held", aw_n, 0);
    wait_resp(15, c);
    chk("stall.latency", c, 15);
    chk("stall.rdata", bus.resp_rdata, 32'h1234_5678);
    release_resp("stall");
    rd_dly = 0;

    // Asynchronous reset while waiting in RD.
    rd_dly = 5;
    issue(1'b0, 32'h8000_0004, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("rstmid.rd_ready_before", bus.rd_ready, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid.rd_ready", bus.rd_ready, 1'b0);
    chk("rstmid.req_ready", bus.req_ready, 1'b1);
    chk("rstmid.resp_valid", bus.resp_valid, 1'b0);
    chk("rstmid.ar_valid", bus.ar_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    rd_dly = 0;
    run_vec('{1'b0, 32'h8000_0000, 32'h0, 4'h0, 2'b00, 32'h1234_5678, 1'b0}, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
